cart_abus_ctrl: RTL and testbench

Parametrised A-bus cartridge controller for the Saturn core. It decodes cartridge-space accesses from the SCU A-bus (CS0/CS1), answers cartridge-ID reads, and translates memory reads and writes into single-beat requests on an external SDRAM/ROM port. Compared with the previous cartridge block it adds a configurable memory address width, a backup-RAM mode and a posted write buffer, so A-bus writes complete without wait states unless the buffer is full. Reads stay ordered behind buffered writes.

---
 rtl/cart_abus_ctrl.sv | 242 ++++++++++++++++++++++++
 tb/tb_cart_abus_ctrl.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cart_abus_ctrl.sv
// A-bus cartridge controller: ID reads, address mapping, posted write FIFO
// with a one-deep staging slot, and a single-outstanding memory request port.
module cart_abus_ctrl #(
    parameter int unsigned MEM_AW     = 21,
    parameter int unsigned WBUF_DEPTH = 4
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic [2:0]                    MODE,
    input  logic [25:0]                   AA,
    input  logic [15:0]                   ADI,
    output logic [15:0]                   ADO,
    input  logic                          ACS0_N,
    input  logic                          ACS1_N,
    input  logic                          ARD_N,
    input  logic                          AWRL_N,
    input  logic                          AWRU_N,
    output logic                          AWAIT_N,
    output logic                          ARQT_N,
    output logic [MEM_AW:1]               MEM_A,
    output logic [15:0]                   MEM_DO,
    output logic [1:0]                    MEM_WE,
    output logic                          MEM_RD,
    input  logic [15:0]                   MEM_DI,
    input  logic                          MEM_RDY,
    output logic [$clog2(WBUF_DEPTH):0]   WBUF_LEVEL
);

    localparam int unsigned PW = $clog2(WBUF_DEPTH);
    localparam int unsigned LW = PW + 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WR   = 2'd1;
    localparam logic [1:0] ST_RD   = 2'd2;

    typedef struct packed {
        logic [MEM_AW-1:0] addr;
        logic [15:0]       data;
        logic [1:0]        we;
    } wentry_t;

    logic              rd_n_q, rd_n_d, wr_n_q, wr_n_d;
    logic [1:0]        state_q, state_d;
    wentry_t           fifo_q [WBUF_DEPTH];
    wentry_t           fifo_d [WBUF_DEPTH];
    logic [PW-1:0]     wp_q, wp_d, rp_q, rp_d;
    logic [LW-1:0]     cnt_q, cnt_d;
    wentry_t           stg_q, stg_d;
    logic              stg_vld_q, stg_vld_d;
    logic              rd_pend_q, rd_pend_d;
    logic [MEM_AW-1:0] rd_addr_q, rd_addr_d;
    logic [15:0]       ado_q, ado_d;
    logic              await_n_q, await_n_d;
    logic [MEM_AW-1:0] mem_a_q, mem_a_d;
    logic [15:0]       mem_do_q, mem_do_d;
    logic [1:0]        mem_we_q, mem_we_d;
    logic              mem_rd_q, mem_rd_d;

    logic [2:0]        eff_mode;
    logic              id_sel, mem_sel, rd_edge, wr_edge, wr_mem, full, pop, push;
    logic [MEM_AW-1:0] map_addr;
    logic [15:0]       id_data;
    wentry_t           new_ent, push_ent;
    logic              unused_aa;

    assign unused_aa = ^{AA[25:24], AA[0]};

    // Input decode: mode folding, selects, strobe edges, address map, ID word
    always_comb begin
        eff_mode = (MODE > 3'd4) ? 3'd0 : MODE;
        id_sel   = (&AA[23:1]) && !ACS1_N;
        mem_sel  = (!ACS0_N || !ACS1_N) && !id_sel;
        rd_edge  = !ARD_N && rd_n_q;
        wr_edge  = !(AWRL_N && AWRU_N) && wr_n_q;
        wr_mem   = wr_edge && mem_sel && (eff_mode >= 3'd2);
        full     = (cnt_q == LW'(WBUF_DEPTH));
        pop      = (state_q == ST_WR) && MEM_RDY;
        case (eff_mode)
            3'd1:    map_addr = MEM_AW'(AA[20:1]);
            3'd2:    map_addr = MEM_AW'({AA[21], AA[18:1]});
            3'd3:    map_addr = MEM_AW'(AA[21:1]);
            3'd4:    map_addr = MEM_AW'(AA[18:1]);
            default: map_addr = '0;
        endcase
        case (eff_mode)
            3'd2:    id_data = 16'hFF5A;
            3'd3:    id_data = 16'hFF5C;
            3'd4:    id_data = 16'hFF21;
            default: id_data = 16'hFFFF;
        endcase
        new_ent.addr = map_addr;
        new_ent.data = ADI;
        new_ent.we   = ~{AWRU_N, AWRL_N};
    end

    // Next state: write buffering, read capture, memory port FSM, wait request
    always_comb begin
        rd_n_d    = ARD_N;
        wr_n_d    = AWRL_N && AWRU_N;
        state_d   = state_q;
        fifo_d    = fifo_q;
        wp_d      = wp_q;
        rp_d      = rp_q;
        cnt_d     = cnt_q;
        stg_d     = stg_q;
        stg_vld_d = stg_vld_q;
        rd_pend_d = rd_pend_q;
        rd_addr_d = rd_addr_q;
        ado_d     = ado_q;
        mem_a_d   = mem_a_q;
        mem_do_d  = mem_do_q;
        mem_we_d  = mem_we_q;
        mem_rd_d  = mem_rd_q;
        push      = 1'b0;
        push_ent  = stg_q;

        // A staged entry takes the first free slot; a slot freed by a pop counts
        if (stg_vld_q) begin
            if (!full || pop) begin
                push      = 1'b1;
                stg_vld_d = 1'b0;
            end
        end else if (wr_mem) begin
            if (!full || pop) begin
                push     = 1'b1;
                push_ent = new_ent;
            end else begin
                stg_d     = new_ent;
                stg_vld_d = 1'b1;
            end
        end

        // A read edge coinciding with a write edge is dropped
        if (rd_edge && !wr_edge) begin
            if (id_sel) begin
                ado_d = id_data;
            end else if (mem_sel) begin
                if (eff_mode == 3'd0) begin
                    ado_d = 16'hFFFF;
                end else begin
                    rd_pend_d = 1'b1;
                    rd_addr_d = map_addr;
                end
            end
        end

        if (push) begin
            fifo_d[wp_q] = push_ent;
            wp_d         = wp_q + PW'(1);
        end
        if (pop) begin
            rp_d = rp_q + PW'(1);
        end
        cnt_d = cnt_q + LW'(push) - LW'(pop);

        case (state_q)
            ST_IDLE: begin
                if (cnt_q != '0) begin
                    state_d  = ST_WR;
                    mem_a_d  = fifo_q[rp_q].addr;
                    mem_do_d = fifo_q[rp_q].data;
                    mem_we_d = fifo_q[rp_q].we;
                end else if (rd_pend_q && !stg_vld_q && !push) begin
                    state_d  = ST_RD;
                    mem_a_d  = rd_addr_q;
                    mem_rd_d = 1'b1;
                end
            end
            ST_WR: begin
                if (MEM_RDY) begin
                    state_d  = ST_IDLE;
                    mem_we_d = 2'b00;
                end
            end
            ST_RD: begin
                if (MEM_RDY) begin
                    state_d   = ST_IDLE;
                    mem_rd_d  = 1'b0;
                    ado_d     = MEM_DI;
                    rd_pend_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        await_n_d = !(rd_pend_d || stg_vld_d);
    end

    // Control and output registers with synchronous reset
    always_ff @(posedge CLK) begin
        if (RST) begin
            rd_n_q    <= 1'b1;
            wr_n_q    <= 1'b1;
            state_q   <= ST_IDLE;
            wp_q      <= '0;
            rp_q      <= '0;
            cnt_q     <= '0;
            stg_q     <= '0;
            stg_vld_q <= 1'b0;
            rd_pend_q <= 1'b0;
            rd_addr_q <= '0;
            ado_q     <= 16'hFFFF;
            await_n_q <= 1'b1;
            mem_a_q   <= '0;
            mem_do_q  <= '0;
            mem_we_q  <= 2'b00;
            mem_rd_q  <= 1'b0;
        end else begin
            rd_n_q    <= rd_n_d;
            wr_n_q    <= wr_n_d;
            state_q   <= state_d;
            wp_q      <= wp_d;
            rp_q      <= rp_d;
            cnt_q     <= cnt_d;
            stg_q     <= stg_d;
            stg_vld_q <= stg_vld_d;
            rd_pend_q <= rd_pend_d;
            rd_addr_q <= rd_addr_d;
            ado_q     <= ado_d;
            await_n_q <= await_n_d;
            mem_a_q   <= mem_a_d;
            mem_do_q  <= mem_do_d;
            mem_we_q  <= mem_we_d;
            mem_rd_q  <= mem_rd_d;
        end
    end

    // FIFO storage; validity is tracked by the pointers, so no reset needed
    always_ff @(posedge CLK) begin
        fifo_q <= fifo_d;
    end

    assign ADO        = ado_q;
    assign AWAIT_N    = await_n_q;
    assign ARQT_N     = 1'b1;
    assign MEM_A      = mem_a_q;
    assign MEM_DO     = mem_do_q;
    assign MEM_WE     = mem_we_q;
    assign MEM_RD     = mem_rd_q;
    assign WBUF_LEVEL = cnt_q;

endmodule

// File: tb/tb_cart_abus_ctrl.sv
// Bench for cart_abus_ctrl: vector table, request scoreboard, timing sequences.
module tb_cart_abus_ctrl;

    logic        CLK, RST;
    logic [2:0]  MODE;
    logic [25:0] AA;
    logic [15:0] ADI, ADO, MEM_DO, MEM_DI;
    logic        ACS0_N, ACS1_N, ARD_N, AWRL_N, AWRU_N;
    logic        AWAIT_N, ARQT_N, MEM_RD, MEM_RDY;
    logic [21:1] MEM_A;
    logic [1:0]  MEM_WE;
    logic [2:0]  WBUF_LEVEL;

    cart_abus_ctrl #(.MEM_AW(21), .WBUF_DEPTH(4)) dut (
        .CLK(CLK), .RST(RST), .MODE(MODE), .AA(AA), .ADI(ADI), .ADO(ADO),
        .ACS0_N(ACS0_N), .ACS1_N(ACS1_N), .ARD_N(ARD_N), .AWRL_N(AWRL_N),
        .AWRU_N(AWRU_N), .AWAIT_N(AWAIT_N), .ARQT_N(ARQT_N), .MEM_A(MEM_A),
        .MEM_DO(MEM_DO), .MEM_WE(MEM_WE), .MEM_RD(MEM_RD), .MEM_DI(MEM_DI),
        .MEM_RDY(MEM_RDY), .WBUF_LEVEL(WBUF_LEVEL)
    );

    typedef struct packed {
        logic        rd;
        logic [20:0] addr;
        logic [15:0] data;
        logic [1:0]  we;
    } req_t;

    typedef struct {
        logic [2:0]  mode;
        logic        is_wr;
        logic [25:0] aa;
        logic        cs1;
        logic [15:0] adi;
        logic [1:0]  lanes;
        logic        exp_req;
        logic [20:0] exp_addr;
        logic [15:0] exp_ado;
        logic        exp_wait;
        logic [15:0] rdata;
    } vec_t;

    int          total = 0;
    int          bad   = 0;
    int          req_seen = 0;
    int          wait_cnt = 0;
    logic        rdy_hold = 1'b0;
    logic [15:0] rd_data  = 16'h0000;
    req_t        exp_q[$];

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Memory model: one-cycle-latency completion pulse unless held off
    initial begin
        MEM_RDY = 1'b0;
        MEM_DI  = 16'h0000;
        forever begin
            @(negedge CLK);
            if (RST) begin
                MEM_RDY  = 1'b0;
                wait_cnt = 0;
            end else if (MEM_RDY) begin
                MEM_RDY = 1'b0;
            end else if ((MEM_RD || MEM_WE != 2'b00) && !rdy_hold) begin
                if (wait_cnt >= 1) begin
                    MEM_RDY  = 1'b1;
                    MEM_DI   = rd_data;
                    wait_cnt = 0;
                end else begin
                    wait_cnt++;
                end
            end
        end
    end

    // Scoreboard: every new request is compared against the oldest expectation
    initial begin
        logic req_prev = 1'b0;
        logic req_now;
        req_t e;
        forever begin
            @(negedge CLK);
            req_now = MEM_RD || (MEM_WE != 2'b00);
            if (req_now && !req_prev) begin
                req_seen++;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL req_unexpected: got rd=%b we=%b a=%h expected none", MEM_RD, MEM_WE, MEM_A);
                end else begin
                    e = exp_q.pop_front();
                    check("req_rd", 32'(MEM_RD), 32'(e.rd));
                    check("req_addr", 32'(MEM_A), 32'(e.addr));
                    check("req_we", 32'(MEM_WE), 32'(e.we));
                    if (!e.rd) check("req_data", 32'(MEM_DO), 32'(e.data));
                end
            end
            req_prev = req_now;
        end
    end

    task automatic do_reset(input logic [2:0] mode);
        @(negedge CLK);
        RST = 1'b1; MODE = mode;
        ACS0_N = 1'b1; ACS1_N = 1'b1; ARD_N = 1'b1; AWRL_N = 1'b1; AWRU_N = 1'b1;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
    endtask

    // One strobe cycle; returns at the half-cycle after the sampling edge
    task automatic bus_op(input logic is_wr, input logic [25:0] aa, input logic cs1,
                          input logic [15:0] d, input logic [1:0] lanes);
        @(negedge CLK);
        AA = aa; ADI = d;
        if (cs1) ACS1_N = 1'b0; else ACS0_N = 1'b0;
        if (is_wr) begin
            AWRU_N = !lanes[1];
            AWRL_N = !lanes[0];
        end else begin
            ARD_N = 1'b0;
        end
        @(negedge CLK);
        ACS0_N = 1'b1; ACS1_N = 1'b1; ARD_N = 1'b1; AWRL_N = 1'b1; AWRU_N = 1'b1;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (!(AWAIT_N && !MEM_RD && MEM_WE == 2'b00 && WBUF_LEVEL == 3'd0 && exp_q.size() == 0)
               && n < 200) begin
            @(negedge CLK);
            n++;
        end
        check({name, "_idle"}, 32'(n < 200), 32'd1);
        repeat (4) @(negedge CLK);
        check({name, "_drain"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic wait_rdy(input string name);
        int n = 0;
        do begin
            @(posedge CLK);
            n++;
        end while (!MEM_RDY && n < 50);
        check({name, "_rdy_seen"}, 32'(MEM_RDY), 32'd1);
    endtask

    function automatic vec_t mk(input logic [2:0] mode, input logic is_wr, input logic [25:0] aa,
                                input logic cs1, input logic [15:0] adi, input logic [1:0] lanes,
                                input logic exp_req, input logic [20:0] exp_addr,
                                input logic [15:0] exp_ado, input logic exp_wait,
                                input logic [15:0] rdata);
        vec_t v;
        v.mode = mode; v.is_wr = is_wr; v.aa = aa; v.cs1 = cs1; v.adi = adi; v.lanes = lanes;
        v.exp_req = exp_req; v.exp_addr = exp_addr; v.exp_ado = exp_ado;
        v.exp_wait = exp_wait; v.rdata = rdata;
        return v;
    endfunction

    vec_t vecs[$];

    initial begin
        req_t r;
        int   seen0;
        RST = 1'b1; MODE = 3'd3; AA = '0; ADI = '0;
        ACS0_N = 1'b1; ACS1_N = 1'b1; ARD_N = 1'b1; AWRL_N = 1'b1; AWRU_N = 1'b1;

        //        mode  wr  aa           cs1  adi       lanes  req  addr       ado       wait rdata
        vecs.push_back(mk(3'd3, 0, 26'h0FFFFFF, 1, 16'h0000, 2'b00, 0, 21'h0,      16'hFF5C, 0, 16'h0));
        vecs.push_back(mk(3'd2, 0, 26'h0FFFFFF, 1, 16'h0000, 2'b00, 0, 21'h0,      16'hFF5A, 0, 16'h0));
        vecs.push_back(mk(3'd4, 0, 26'h0FFFFFF, 1, 16'h0000, 2'b00, 0, 21'h0,      16'hFF21, 0, 16'h0));
        vecs.push_back(mk(3'd1, 0, 26'h0FFFFFF, 1, 16'h0000, 2'b00, 0, 21'h0,      16'hFFFF, 0, 16'h0));
        vecs.push_back(mk(3'd6, 0, 26'h0FFFFFF, 1, 16'h0000, 2'b00, 0, 21'h0,      16'hFFFF, 0, 16'h0));
        vecs.push_back(mk(3'd3, 1, 26'h0200002, 0, 16'h1234, 2'b11, 1, 21'h100001, 16'hFFFF, 0, 16'h0));
        vecs.push_back(mk(3'd2, 1, 26'h0240004, 0, 16'hABCD, 2'b10, 1, 21'h060002, 16'hFFFF, 0, 16'h0));
        vecs.push_back(mk(3'd4, 1, 26'h0080010, 1, 16'h0055, 2'b01, 1, 21'h000008, 16'hFFFF, 0, 16'h0));
        vecs.push_back(mk(3'd1, 1, 26'h0000100, 0, 16'h7777, 2'b11, 0, 21'h0,      16'hFFFF, 0, 16'h0));
        vecs.push_back(mk(3'd7, 1, 26'h0000100, 0, 16'h7777, 2'b11, 0, 21'h0,      16'hFFFF, 0, 16'h0));
        vecs.push_back(mk(3'd3, 1, 26'h0FFFFFF, 1, 16'h4444, 2'b11, 0, 21'h0,      16'hFFFF, 0, 16'h0));
        vecs.push_back(mk(3'd0, 0, 26'h0001000, 0, 16'h0000, 2'b00, 0, 21'h0,      16'hFFFF, 0, 16'h0));
        vecs.push_back(mk(3'd1, 0, 26'h0123456, 0, 16'h0000, 2'b00, 1, 21'h091A2B, 16'h5A5A, 1, 16'h5A5A));
        vecs.push_back(mk(3'd3, 0, 26'h0FFFFFF, 0, 16'h0000, 2'b00, 1, 21'h1FFFFF, 16'hC3C3, 1, 16'hC3C3));
        vecs.push_back(mk(3'd2, 0, 26'h0240004, 0, 16'h0000, 2'b00, 1, 21'h060002, 16'h0F0F, 1, 16'h0F0F));

        // Reset values
        do_reset(3'd3);
        @(negedge CLK);
        check("rst_ado", 32'(ADO), 32'hFFFF);
        check("rst_await", 32'(AWAIT_N), 32'd1);
        check("rst_arqt", 32'(ARQT_N), 32'd1);
        check("rst_mem_a", 32'(MEM_A), 32'd0);
        check("rst_mem_do", 32'(MEM_DO), 32'd0);
        check("rst_mem_we", 32'(MEM_WE), 32'd0);
        check("rst_mem_rd", 32'(MEM_RD), 32'd0);
        check("rst_level", 32'(WBUF_LEVEL), 32'd0);

        // Table-driven single accesses
        foreach (vecs[i]) begin
            do_reset(vecs[i].mode);
            rd_data = vecs[i].rdata;
            if (vecs[i].exp_req) begin
                r.rd = !vecs[i].is_wr; r.addr = vecs[i].exp_addr;
                r.data = vecs[i].adi; r.we = vecs[i].is_wr ? vecs[i].lanes : 2'b00;
                exp_q.push_back(r);
            end
            bus_op(vecs[i].is_wr, vecs[i].aa, vecs[i].cs1, vecs[i].adi, vecs[i].lanes);
            check($sformatf("v%0d_await", i), 32'(AWAIT_N), 32'(!vecs[i].exp_wait));
            wait_idle($sformatf("v%0d", i));
            if (!vecs[i].is_wr) check($sformatf("v%0d_ado", i), 32'(ADO), 32'(vecs[i].exp_ado));
        end

        // Write timing: push at N+1, request at N+2, held until MEM_RDY, drops after
        do_reset(3'd3);
        rdy_hold = 1'b1;
        exp_q.push_back('{1'b0, 21'h000010, 16'hBEEF, 2'b11});
        bus_op(1'b1, 26'h0000020, 1'b0, 16'hBEEF, 2'b11);
        check("wt_level_n1", 32'(WBUF_LEVEL), 32'd1);
        check("wt_await_n1", 32'(AWAIT_N), 32'd1);
        check("wt_we_n1", 32'(MEM_WE), 32'd0);
        @(negedge CLK);
        check("wt_we_n2", 32'(MEM_WE), 32'h3);
        check("wt_a_n2", 32'(MEM_A), 32'h10);
        check("wt_do_n2", 32'(MEM_DO), 32'hBEEF);
        repeat (3) @(negedge CLK);
        check("wt_we_hold", 32'(MEM_WE), 32'h3);
        rdy_hold = 1'b0;
        wait_rdy("wt");
        @(negedge CLK);
        check("wt_we_drop", 32'(MEM_WE), 32'd0);
        check("wt_level_pop", 32'(WBUF_LEVEL), 32'd0);
        wait_idle("wt");

        // Read timing with empty FIFO: wait at N+1, MEM_RD at N+2, data at K+1
        do_reset(3'd3);
        rd_data = 16'h2468;
        exp_q.push_back('{1'b1, 21'h000040, 16'h0000, 2'b00});
        bus_op(1'b0, 26'h0000080, 1'b0, 16'h0000, 2'b00);
        check("rt_await_n1", 32'(AWAIT_N), 32'd0);
        check("rt_rd_n1", 32'(MEM_RD), 32'd0);
        @(negedge CLK);
        check("rt_rd_n2", 32'(MEM_RD), 32'd1);
        wait_rdy("rt");
        @(negedge CLK);
        check("rt_rd_drop", 32'(MEM_RD), 32'd0);
        check("rt_await_rel", 32'(AWAIT_N), 32'd1);
        check("rt_ado", 32'(ADO), 32'h2468);
        wait_idle("rt");

        // FIFO full: four posted writes free, fifth stalls until first completion
        do_reset(3'd3);
        rdy_hold = 1'b1;
        for (int k = 0; k < 5; k++)
            exp_q.push_back('{1'b0, 21'(32'h200 + k), 16'(32'hA000 + k), 2'b11});
        for (int k = 0; k < 5; k++) begin
            bus_op(1'b1, 26'(32'h400 + 2 * k), 1'b0, 16'(32'hA000 + k), 2'b11);
            check($sformatf("ff_await_w%0d", k), 32'(AWAIT_N), (k < 4) ? 32'd1 : 32'd0);
            if (k == 3) check("ff_level_full", 32'(WBUF_LEVEL), 32'd4);
        end
        repeat (3) @(negedge CLK);
        check("ff_await_hold", 32'(AWAIT_N), 32'd0);
        check("ff_level_hold", 32'(WBUF_LEVEL), 32'd4);
        rdy_hold = 1'b0;
        wait_rdy("ff");
        @(negedge CLK);
        check("ff_await_rise", 32'(AWAIT_N), 32'd1);
        check("ff_level_xfer", 32'(WBUF_LEVEL), 32'd4);
        wait_idle("ff");

        // Read ordered behind three posted writes
        do_reset(3'd3);
        rd_data = 16'h9999;
        for (int k = 0; k < 3; k++)
            exp_q.push_back('{1'b0, 21'(32'h8 * (k + 1)), 16'(32'h1100 * (k + 1)), 2'b11});
        exp_q.push_back('{1'b1, 21'h000018, 16'h0000, 2'b00});
        seen0 = req_seen;
        for (int k = 0; k < 3; k++)
            bus_op(1'b1, 26'(32'h10 * (k + 1)), 1'b0, 16'(32'h1100 * (k + 1)), 2'b11);
        bus_op(1'b0, 26'h0000030, 1'b0, 16'h0000, 2'b00);
        check("ord_await_low", 32'(AWAIT_N), 32'd0);
        begin
            int n = 0;
            while (!AWAIT_N && n < 200) begin
                @(negedge CLK);
                n++;
            end
        end
        check("ord_req_count", 32'(req_seen - seen0), 32'd4);
        check("ord_ado", 32'(ADO), 32'h9999);
        wait_idle("ord");

        // Reset during an outstanding read
        do_reset(3'd3);
        rdy_hold = 1'b1;
        exp_q.push_back('{1'b1, 21'h000100, 16'h0000, 2'b00});
        bus_op(1'b0, 26'h0000200, 1'b0, 16'h0000, 2'b00);
        @(negedge CLK);
        check("rr_rd_active", 32'(MEM_RD), 32'd1);
        RST = 1'b1;
        @(negedge CLK);
        check("rr_rd_cleared", 32'(MEM_RD), 32'd0);
        check("rr_await", 32'(AWAIT_N), 32'd1);
        check("rr_ado", 32'(ADO), 32'hFFFF);
        RST = 1'b0;
        rdy_hold = 1'b0;
        wait_idle("rr");

        // Reset with writes buffered discards them
        do_reset(3'd3);
        rdy_hold = 1'b1;
        exp_q.push_back('{1'b0, 21'h000001, 16'h0101, 2'b11});
        bus_op(1'b1, 26'h0000002, 1'b0, 16'h0101, 2'b11);
        bus_op(1'b1, 26'h0000004, 1'b0, 16'h0202, 2'b11);
        check("rw_level_pre", 32'(WBUF_LEVEL), 32'd2);
        RST = 1'b1;
        @(negedge CLK);
        check("rw_level_rst", 32'(WBUF_LEVEL), 32'd0);
        check("rw_we_rst", 32'(MEM_WE), 32'd0);
        RST = 1'b0;
        rdy_hold = 1'b0;
        wait_idle("rw");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
